cmd_dispatch_fsm: RTL

CMD_DISPATCH_FSM -- requirements
Module: cmd_dispatch_fsm

---
 rtl/cmd_dispatch_fsm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cmd_dispatch_fsm.sv
// Command dispatcher: pops one opcode per request, launches the matching sub-FSM
// (or a soft reset) and writes result/status to the output FIFO, with a watchdog fallback.
module cmd_dispatch_fsm #(
   parameter int word_size = 16,
   parameter int num_modes = 4,
   parameter int op_width  = 3,
   parameter int timeout   = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start_in,
   input  logic                           cmd_empty,
   input  logic [word_size-1:0]           cmd_in,
   output logic                           cmd_rd_en,
   output logic [num_modes-1:0]           sub_start,
   input  logic [num_modes-1:0]           sub_done,
   input  logic [num_modes*word_size-1:0] sub_result,
   input  logic [num_modes*word_size-1:0] sub_status,
   input  logic                           out_full,
   output logic                           out_wr_en,
   output logic [word_size-1:0]           result,
   output logic [word_size-1:0]           status,
   output logic                           soft_rst,
   output logic                           done_out,
   output logic                           busy
);
   localparam logic [31:0]          NMODES   = 32'(num_modes);
   localparam logic [15:0]          WD_LAST  = 16'(timeout - 1);
   localparam logic [word_size-1:0] ST_BADOP = word_size'(16'hFFFE);
   localparam logic [word_size-1:0] ST_TMO   = word_size'(16'hFFFF);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_START, S_WAIT, S_SRST, S_WRITE, S_DONE
   } state_t;

   state_t               r_state, w_next;
   logic                 r_pend;
   logic [op_width-1:0]  r_op;
   logic [15:0]          r_wdog;
   logic [word_size-1:0] r_result, r_status;
   logic [31:0]          w_cmd_op, w_cur_op;
   logic                 w_done, w_tmo, w_unused;
   logic [word_size-1:0] w_sel_res, w_sel_sts;

   // Opcodes are zero-extended to 32 bits so num_modes is never truncated.
   assign w_cmd_op = 32'(cmd_in[op_width-1:0]);
   assign w_cur_op = 32'(r_op);
   assign w_tmo    = (r_wdog == WD_LAST);
   assign w_unused = ^cmd_in;

   always_comb begin
      w_done    = 1'b0;
      w_sel_res = '0;
      w_sel_sts = '0;
      for (int i = 0; i < num_modes; i++) begin
         if (w_cur_op == 32'(i)) begin
            w_done    = sub_done[i];
            w_sel_res = sub_result[i*word_size +: word_size];
            w_sel_sts = sub_status[i*word_size +: word_size];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if ((r_pend || start_in) && !cmd_empty) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (w_cmd_op < NMODES)       w_next = S_START;
            else if (w_cmd_op == NMODES) w_next = S_SRST;
            else                         w_next = S_WRITE;
         end
         S_START:  w_next = S_WAIT;
         S_WAIT:   if (w_done || w_tmo) w_next = S_WRITE;
         S_SRST:   w_next = S_DONE;
         S_WRITE:  if (!out_full) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend   <= 1'b0;
         r_op     <= '0;
         r_wdog   <= '0;
         r_result <= '0;
         r_status <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_next == S_FETCH) r_pend <= 1'b0;
               else if (start_in)     r_pend <= 1'b1;
            end
            S_DECODE: begin
               r_op <= cmd_in[op_width-1:0];
               if (w_cmd_op > NMODES) begin
                  r_result <= '0;
                  r_status <= ST_BADOP;
               end
            end
            S_START: r_wdog <= '0;
            S_WAIT: begin
               // A done arriving on the final watchdog cycle takes priority.
               if (w_done) begin
                  r_result <= w_sel_res;
                  r_status <= w_sel_sts;
               end else if (w_tmo) begin
                  r_result <= '0;
                  r_status <= ST_TMO;
               end else begin
                  r_wdog <= r_wdog + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes are gated by rst so they are low for the whole reset cycle too.
   assign cmd_rd_en = rst && (r_state == S_FETCH);
   assign out_wr_en = rst && (r_state == S_WRITE) && !out_full;
   assign soft_rst  = rst && (r_state == S_SRST);
   assign done_out  = rst && (r_state == S_DONE);
   assign busy      = rst && (r_state != S_IDLE);
   assign result    = r_result;
   assign status    = r_status;

   always_comb begin
      sub_start = '0;
      for (int i = 0; i < num_modes; i++)
         sub_start[i] = rst && (r_state == S_START) && (w_cur_op == 32'(i));
   end

endmodule
